// File: rtl/pipeline_pkg.sv
// Shared fetch-stage types and constants.
// Used by the prefetch queue and its FIFO.
package pipeline_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      KILL
   } fetch_state_t;

   localparam logic [31:0] INST_NOP   = 32'h0000_0000;
   localparam logic [31:0] WORD_BYTES = 32'd4;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc_plus4;
   } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO of fetched instructions with clear.
// Pop on empty is ignored; clear wins over push and pop.
module inst_fifo
   import pipeline_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         clear,
   input  fetch_entry_t                 wdata,
   output fetch_entry_t                 rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;

   assign do_pop = pop && (count != '0);
   assign rdata  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr] <= wdata;
   end

   // The fetch FSM never issues a request without a free slot
   a_no_overflow : assert property (
      @(posedge clk) disable iff (!rst)
      !(push && !clear && count == FULL)
   );

endmodule

// File: rtl/inst_prefetch_queue.sv
// Fetch PC owner, memory req/ack sequencer and prefetch buffer.
// Redirects flush the queue; an in-flight fetch is completed then dropped.
module inst_prefetch_queue
   import pipeline_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        deq,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc_plus4
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   fetch_state_t  state, state_nx;
   logic [31:0]   fetch_pc, pc_nx;
   logic [31:0]   redir_pc, rpc_nx;
   logic [CW-1:0] count;
   logic [CW:0]   cnt_nx;
   logic          push, pop, room;
   fetch_entry_t  head, wdata;

   assign inst_valid = (count != '0);
   assign push = (state == WAIT) && mem_ack && !redirect;
   assign pop  = deq && inst_valid && !redirect;

   // Occupancy after this cycle; the next request reserves one more slot
   assign cnt_nx = {1'b0, count} + (CW + 1)'(push) - (CW + 1)'(pop);
   assign room   = (cnt_nx < DEPTH_W);

   assign wdata.inst     = mem_rdata;
   assign wdata.pc_plus4 = fetch_pc + WORD_BYTES;

   assign mem_req  = (state == WAIT) || (state == KILL);
   assign mem_addr = fetch_pc;

   assign inst          = inst_valid ? head.inst : INST_NOP;
   assign inst_pc_plus4 = inst_valid ? head.pc_plus4 : 32'h0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         redir_pc <= RESET_PC;
      end else begin
         state    <= state_nx;
         fetch_pc <= pc_nx;
         redir_pc <= rpc_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pc_nx    = fetch_pc;
      rpc_nx   = redir_pc;
      unique case (state)
         IDLE: begin
            if (redirect)  pc_nx    = redirect_pc;
            else if (room) state_nx = WAIT;
         end
         WAIT: begin
            if (redirect && mem_ack) begin
               pc_nx    = redirect_pc;
               state_nx = IDLE;
            end else if (redirect) begin
               rpc_nx   = redirect_pc;
               state_nx = KILL;
            end else if (mem_ack) begin
               pc_nx    = fetch_pc + WORD_BYTES;
               state_nx = room ? WAIT : IDLE;
            end
         end
         KILL: begin
            // mem_addr must stay on the squashed word until it is acked
            if (redirect) rpc_nx = redirect_pc;
            if (mem_ack) begin
               pc_nx    = redirect ? redirect_pc : redir_pc;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   inst_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .clear (redirect),
      .wdata (wdata),
      .rdata (head),
      .count (count)
   );

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue with a scripted memory.
// Memory returns ~addr as the instruction word.
module tb_inst_prefetch_queue;

   logic        clk;
   logic        rst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        deq;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc_plus4;

   logic        zw;
   logic        ack_drv;
   logic [31:0] rdata_drv;
   int          n_chk;
   int          n_fail;

   assign mem_ack   = zw ? mem_req : ack_drv;
   assign mem_rdata = zw ? ~mem_addr : rdata_drv;

   inst_prefetch_queue #(
      .DEPTH(4),
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .deq           (deq),
      .inst_valid    (inst_valid),
      .inst          (inst),
      .inst_pc_plus4 (inst_pc_plus4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst         = 1'b0;
      zw          = 1'b0;
      ack_drv     = 1'b0;
      rdata_drv   = 32'h0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      deq         = 1'b0;
      repeat (2) step();
      rst = 1'b1;
   endtask

   // Wait (bounded) for a request, hold it lat cycles, ack for one edge
   task automatic ack_next(input int lat, output logic [31:0] a);
      for (int t = 0; t < 20 && !mem_req; t++) step();
      if (!mem_req) begin
         a = 32'hDEAD_BEEF;
         return;
      end
      a = mem_addr;
      repeat (lat) step();
      ack_drv   = 1'b1;
      rdata_drv = ~a;
      step();
      ack_drv = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      zw        = 1'b0;
      ack_drv   = 1'b0;
      rdata_drv = 32'h0;
      redirect  = 1'b0;
      redirect_pc = 32'h0;
      deq       = 1'b0;
      step();
      n_chk++;
      if (mem_req !== 1'b0) begin
         $display("FAIL rst_req got %b want 0", mem_req);
         n_fail++;
      end
      n_chk++;
      if (inst_valid !== 1'b0) begin
         $display("FAIL rst_valid got %b want 0", inst_valid);
         n_fail++;
      end
      n_chk++;
      if (inst !== 32'h0) begin
         $display("FAIL rst_inst got %h want 0", inst);
         n_fail++;
      end
      n_chk++;
      if (inst_pc_plus4 !== 32'h0) begin
         $display("FAIL rst_pc4 got %h want 0", inst_pc_plus4);
         n_fail++;
      end
      n_chk++;
      if (mem_addr !== 32'h0) begin
         $display("FAIL rst_addr got %h want 0", mem_addr);
         n_fail++;
      end
   endtask

   task automatic test_fill();
      logic [31:0] a;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ack_next(1, a);
         n_chk++;
         if (a !== 32'(i * 4)) begin
            $display("FAIL fill_addr%0d got %h want %h", i, a, 32'(i * 4));
            n_fail++;
         end
      end
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if (mem_req !== 1'b0) begin
            $display("FAIL fill_req_off%0d got %b want 0", i, mem_req);
            n_fail++;
         end
         step();
      end
      n_chk++;
      if (inst_pc_plus4 !== 32'h4) begin
         $display("FAIL fill_pc4 got %h want 4", inst_pc_plus4);
         n_fail++;
      end
      n_chk++;
      if (inst !== 32'hFFFF_FFFF) begin
         $display("FAIL fill_inst got %h want ffffffff", inst);
         n_fail++;
      end
   endtask

   task automatic test_stream();
      logic [31:0] exp;
      do_reset();
      zw  = 1'b1;
      deq = 1'b1;
      for (int t = 0; t < 10 && !inst_valid; t++) step();
      exp = 32'h4;
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (inst_valid !== 1'b1 || inst_pc_plus4 !== exp) begin
            $display("FAIL stream%0d got v=%b pc4=%h want v=1 pc4=%h",
                     i, inst_valid, inst_pc_plus4, exp);
            n_fail++;
         end
         n_chk++;
         if (inst !== ~(exp - 32'h4)) begin
            $display("FAIL stream_inst%0d got %h want %h",
                     i, inst, ~(exp - 32'h4));
            n_fail++;
         end
         step();
         exp = exp + 32'h4;
      end
      zw  = 1'b0;
      deq = 1'b0;
   endtask

   task automatic test_redirect_wait();
      logic [31:0] a;
      do_reset();
      ack_next(0, a);
      ack_next(0, a);
      n_chk++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
         $display("FAIL rw_pre got req=%b addr=%h want req=1 addr=8",
                  mem_req, mem_addr);
         n_fail++;
      end
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      step();
      redirect = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_chk++;
         if (mem_req !== 1'b1 || mem_addr !== 32'h8 || inst_valid !== 1'b0) begin
            $display("FAIL rw_kill%0d got req=%b addr=%h v=%b want 1 8 0",
                     i, mem_req, mem_addr, inst_valid);
            n_fail++;
         end
         step();
      end
      ack_drv   = 1'b1;
      rdata_drv = 32'h1234_5678;
      step();
      ack_drv = 1'b0;
      n_chk++;
      if (mem_req !== 1'b0 || inst_valid !== 1'b0) begin
         $display("FAIL rw_drop got req=%b v=%b want 0 0", mem_req, inst_valid);
         n_fail++;
      end
      ack_next(0, a);
      n_chk++;
      if (a !== 32'h100) begin
         $display("FAIL rw_addr got %h want 100", a);
         n_fail++;
      end
      n_chk++;
      if (inst_valid !== 1'b1 || inst_pc_plus4 !== 32'h104) begin
         $display("FAIL rw_pc4 got v=%b pc4=%h want 1 104", inst_valid, inst_pc_plus4);
         n_fail++;
      end
   endtask

   task automatic test_redirect_ack();
      logic [31:0] a;
      do_reset();
      ack_next(0, a);
      n_chk++;
      if (mem_addr !== 32'h4 || inst_valid !== 1'b1) begin
         $display("FAIL ra_pre got addr=%h v=%b want 4 1", mem_addr, inst_valid);
         n_fail++;
      end
      ack_drv     = 1'b1;
      rdata_drv   = 32'hCAFE_0004;
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      step();
      ack_drv  = 1'b0;
      redirect = 1'b0;
      n_chk++;
      if (inst_valid !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h200) begin
         $display("FAIL ra_post got v=%b req=%b addr=%h want 0 0 200",
                  inst_valid, mem_req, mem_addr);
         n_fail++;
      end
      ack_next(0, a);
      n_chk++;
      if (a !== 32'h200 || inst_pc_plus4 !== 32'h204) begin
         $display("FAIL ra_next got addr=%h pc4=%h want 200 204", a, inst_pc_plus4);
         n_fail++;
      end
   endtask

   task automatic test_full_deq();
      logic [31:0] a;
      do_reset();
      for (int i = 0; i < 3; i++) ack_next(0, a);
      n_chk++;
      if (mem_addr !== 32'hC || inst_pc_plus4 !== 32'h4) begin
         $display("FAIL fd_pre got addr=%h pc4=%h want c 4", mem_addr, inst_pc_plus4);
         n_fail++;
      end
      deq       = 1'b1;
      ack_drv   = 1'b1;
      rdata_drv = ~32'hC;
      step();
      ack_drv = 1'b0;
      deq     = 1'b0;
      n_chk++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
         $display("FAIL fd_wait got req=%b addr=%h want 1 10", mem_req, mem_addr);
         n_fail++;
      end
      deq = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (inst_valid !== 1'b1 || inst_pc_plus4 !== 32'(8 + 4 * i)) begin
            $display("FAIL fd_drain%0d got v=%b pc4=%h want 1 %h",
                     i, inst_valid, inst_pc_plus4, 32'(8 + 4 * i));
            n_fail++;
         end
         step();
      end
      for (int i = 0; i < 3; i++) begin
         n_chk++;
         if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc_plus4 !== 32'h0) begin
            $display("FAIL fd_empty%0d got v=%b inst=%h pc4=%h want 0 0 0",
                     i, inst_valid, inst, inst_pc_plus4);
            n_fail++;
         end
         step();
      end
      deq = 1'b0;
      ack_next(0, a);
      n_chk++;
      if (a !== 32'h10 || inst_valid !== 1'b1 || inst_pc_plus4 !== 32'h14) begin
         $display("FAIL fd_after got addr=%h v=%b pc4=%h want 10 1 14",
                  a, inst_valid, inst_pc_plus4);
         n_fail++;
      end
      n_chk++;
      if (inst !== ~32'h10) begin
         $display("FAIL fd_inst got %h want %h", inst, ~32'h10);
         n_fail++;
      end
   endtask

   task automatic test_pc_wrap();
      logic [31:0] a;
      do_reset();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      n_chk++;
      if (mem_req !== 1'b0 || mem_addr !== 32'hFFFF_FFFC) begin
         $display("FAIL wrap_idle got req=%b addr=%h want 0 fffffffc", mem_req, mem_addr);
         n_fail++;
      end
      ack_next(0, a);
      n_chk++;
      if (a !== 32'hFFFF_FFFC || inst_valid !== 1'b1 || inst_pc_plus4 !== 32'h0) begin
         $display("FAIL wrap_pc4 got addr=%h v=%b pc4=%h want fffffffc 1 0",
                  a, inst_valid, inst_pc_plus4);
         n_fail++;
      end
      n_chk++;
      if (mem_addr !== 32'h0) begin
         $display("FAIL wrap_next got %h want 0", mem_addr);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] a;
      do_reset();
      ack_next(0, a);
      n_chk++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
         $display("FAIL rm_pre got req=%b addr=%h want 1 4", mem_req, mem_addr);
         n_fail++;
      end
      #3;
      rst = 1'b0;
      #1;
      n_chk++;
      if (mem_req !== 1'b0 || inst_valid !== 1'b0 || mem_addr !== 32'h0) begin
         $display("FAIL rm_async got req=%b v=%b addr=%h want 0 0 0",
                  mem_req, inst_valid, mem_addr);
         n_fail++;
      end
      step();
      rst = 1'b1;
      ack_next(0, a);
      n_chk++;
      if (a !== 32'h0 || inst_pc_plus4 !== 32'h4) begin
         $display("FAIL rm_restart got addr=%h pc4=%h want 0 4", a, inst_pc_plus4);
         n_fail++;
      end
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      test_reset();
      test_fill();
      test_stream();
      test_redirect_wait();
      test_redirect_ack();
      test_full_deq();
      test_pc_wrap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
